// File: rtl/acc_cpu_param.sv
// Parametrised accumulator CPU core: one externally supplied instruction per valid cycle, with flags and a halt state.
// Build option: define ACC_CPU_SAT_EN to make ADD unsigned-saturating instead of wrapping.
module acc_cpu_param #(
    parameter int DATA_W = 8,
    parameter int REG_N  = 8,
    parameter int PC_W   = 8,
    parameter int INS_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INS_W-1:0]  ins_i,
    input  logic              ins_valid_i,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] acc_o,
    output logic              zero_o,
    output logic              carry_o,
    output logic              halted_o
);
    localparam int REG_AW = (REG_N > 1) ? $clog2(REG_N) : 1;

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_t;

    typedef struct packed {
        logic              load;
        logic [1:0]        op;
        logic [2:0]        sub;
        logic [REG_AW-1:0] ra;
    } dec_t;

    state_t                         state, state_n;
    dec_t                           d;
    logic [REG_N-1:0][DATA_W-1:0]   bank;
    logic signed [INS_W-2:0]        imm;
    logic [DATA_W-1:0]              rd;
    logic [DATA_W:0]                sum;
    logic [DATA_W-1:0]              acc_n;
    logic [PC_W-1:0]                pc_n;
    logic                           carry_n, zero_n, acc_wr, bank_wr, exec;

    always_comb begin
        d.load = ins_i[INS_W-1];
        d.op   = ins_i[INS_W-2:INS_W-3];
        d.sub  = ins_i[2:0];
        d.ra   = ins_i[REG_AW-1:0];
    end

    assign imm  = ins_i[INS_W-2:0];
    assign rd   = bank[d.ra];
    assign exec = ins_valid_i && (state == S_RUN);

    always_comb begin
        state_n = state;
        acc_n   = acc_o;
        pc_n    = pc_o;
        carry_n = carry_o;
        zero_n  = zero_o;
        acc_wr  = 1'b0;
        bank_wr = 1'b0;
        sum     = {1'b0, rd} + {1'b0, acc_o};
        if (exec) begin
            pc_n = pc_o + PC_W'(1);
            if (d.load) begin
                acc_n  = DATA_W'(imm);
                acc_wr = 1'b1;
            end else begin
                case (d.op)
                    2'b01: bank_wr = 1'b1;
                    2'b10: begin
`ifdef ACC_CPU_SAT_EN
                        acc_n   = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
`else
                        acc_n   = sum[DATA_W-1:0];
`endif
                        carry_n = sum[DATA_W];
                        acc_wr  = 1'b1;
                    end
                    // Branch target replaces pc+1; acc=0 yields a legal self-loop.
                    2'b11: if (rd > acc_o) pc_n = pc_o - PC_W'(acc_o);
                    default: begin
                        case (d.sub)
                            3'b001: begin acc_n = ~acc_o; acc_wr = 1'b1; end
                            3'b010: begin acc_n = -acc_o; acc_wr = 1'b1; end
                            3'b011: begin
                                {carry_n, acc_n} = {acc_o, 1'b0};
                                acc_wr = 1'b1;
                            end
                            3'b100: begin
                                acc_n   = {acc_o[DATA_W-1], acc_o[DATA_W-1:1]};
                                carry_n = acc_o[0];
                                acc_wr  = 1'b1;
                            end
                            3'b101: state_n = S_HALT;
                            default: ;
                        endcase
                    end
                endcase
            end
            if (acc_wr) zero_n = (acc_n == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_RUN;
            pc_o    <= '0;
            acc_o   <= '0;
            zero_o  <= 1'b0;
            carry_o <= 1'b0;
            bank    <= '0;
        end else begin
            state   <= state_n;
            pc_o    <= pc_n;
            acc_o   <= acc_n;
            zero_o  <= zero_n;
            carry_o <= carry_n;
            if (bank_wr) bank[d.ra] <= acc_o;
        end
    end

    assign halted_o = (state == S_HALT);
endmodule

// File: tb/tb_acc_cpu_param.sv
// Bench for acc_cpu_param: integer-arithmetic reference model checked every cycle, plus literal checkpoints.
module tb_acc_cpu_param;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] ins_i;
    logic       ins_valid_i;
    logic [7:0] pc_o, acc_o;
    logic       zero_o, carry_o, halted_o;

    acc_cpu_param dut (
        .clk(clk), .rst(rst), .ins_i(ins_i), .ins_valid_i(ins_valid_i),
        .pc_o(pc_o), .acc_o(acc_o), .zero_o(zero_o), .carry_o(carry_o), .halted_o(halted_o)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model in plain integers
    int m_acc, m_pc, m_zero, m_carry, m_halt;
    int m_bank [8];
    bit chk_en = 1'b0;
    int ra, op, sub, imm, s, old_pc;

    always @(posedge clk) begin
        if (rst) begin
            m_acc = 0; m_pc = 0; m_zero = 0; m_carry = 0; m_halt = 0;
            for (int i = 0; i < 8; i++) m_bank[i] = 0;
            chk_en = 1'b1;
        end else if (ins_valid_i && m_halt == 0) begin
            ra = int'(ins_i[2:0]);
            sub = int'(ins_i[2:0]);
            op = int'(ins_i[4:3]);
            old_pc = m_pc;
            m_pc = (old_pc + 1) % 256;
            if (ins_i[5]) begin
                imm = int'(ins_i[4:0]);
                if (imm >= 16) imm -= 32;
                m_acc = (imm + 256) % 256;
                m_zero = (m_acc == 0);
            end else if (op == 1) begin
                m_bank[ra] = m_acc;
            end else if (op == 2) begin
                s = m_bank[ra] + m_acc;
                m_carry = (s > 255);
`ifdef ACC_CPU_SAT_EN
                m_acc = (s > 255) ? 255 : s;
`else
                m_acc = s % 256;
`endif
                m_zero = (m_acc == 0);
            end else if (op == 3) begin
                if (m_bank[ra] > m_acc) m_pc = (old_pc - m_acc + 256) % 256;
            end else begin
                case (sub)
                    1: begin m_acc = 255 - m_acc; m_zero = (m_acc == 0); end
                    2: begin m_acc = (256 - m_acc) % 256; m_zero = (m_acc == 0); end
                    3: begin m_carry = (m_acc >= 128); m_acc = (m_acc * 2) % 256; m_zero = (m_acc == 0); end
                    4: begin
                        m_carry = m_acc % 2;
                        m_acc = m_acc / 2 + ((m_acc >= 128) ? 128 : 0);
                        m_zero = (m_acc == 0);
                    end
                    5: m_halt = 1;
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_acc", int'(acc_o), m_acc);
            check("model_pc", int'(pc_o), m_pc);
            check("model_zero", int'(zero_o), m_zero);
            check("model_carry", int'(carry_o), m_carry);
            check("model_halted", int'(halted_o), m_halt);
        end
    end

    task automatic issue(input logic [5:0] ins, input logic v, input logic r);
        @(negedge clk);
        ins_i = ins; ins_valid_i = v; rst = r;
    endtask

    task automatic lit(input string name, input int acc, input int pc, input int z, input int c, input int h);
        @(posedge clk);
        #1;
        if (acc >= 0) check({name, "_acc"}, int'(acc_o), acc);
        if (pc >= 0)  check({name, "_pc"}, int'(pc_o), pc);
        if (z >= 0)   check({name, "_zero"}, int'(zero_o), z);
        if (c >= 0)   check({name, "_carry"}, int'(carry_o), c);
        if (h >= 0)   check({name, "_halted"}, int'(halted_o), h);
    endtask

    initial begin
        rst = 1'b1; ins_i = '0; ins_valid_i = 1'b0;
        issue(6'b000000, 1'b0, 1'b1);
        lit("reset", 0, 0, 0, 0, 0);

        issue(6'b100101, 1'b1, 1'b0);
        issue(6'b001010, 1'b1, 1'b0);
        issue(6'b100011, 1'b1, 1'b0);
        issue(6'b010010, 1'b1, 1'b0);
        lit("add", 8, 4, 0, 0, 0);

        issue(6'b100011, 1'b1, 1'b0);
        issue(6'b011010, 1'b1, 1'b0);
        lit("br_taken", 3, 2, -1, -1, -1);
        issue(6'b101111, 1'b1, 1'b0);
        issue(6'b011010, 1'b1, 1'b0);
        lit("br_not", 15, 4, -1, -1, -1);

        issue(6'b111111, 1'b1, 1'b0);
        issue(6'b001000, 1'b1, 1'b0);
        issue(6'b010000, 1'b1, 1'b0);
`ifdef ACC_CPU_SAT_EN
        lit("carry", 255, 7, 0, 1, -1);
`else
        lit("carry", 254, 7, 0, 1, -1);
`endif

        issue(6'b100001, 1'b1, 1'b0);
        issue(6'b000010, 1'b1, 1'b0);
        lit("neg", 255, 9, 0, -1, -1);
        issue(6'b000100, 1'b1, 1'b0);
        lit("shr", 255, 10, 0, 1, -1);
        issue(6'b000001, 1'b1, 1'b0);
        lit("not", 0, 11, 1, 1, -1);
        issue(6'b110000, 1'b1, 1'b0);
        issue(6'b000011, 1'b1, 1'b0);
        lit("shl", 224, 13, 0, 1, -1);

        issue(6'b100000, 1'b1, 1'b0);
        issue(6'b011010, 1'b1, 1'b0);
        issue(6'b011010, 1'b1, 1'b0);
        lit("selfloop", 0, 14, 1, -1, 0);

        for (int i = 0; i < 5; i++) issue(6'b100101, 1'b0, 1'b0);
        lit("novalid", 0, 14, 1, 1, 0);

        issue(6'b000101, 1'b1, 1'b0);
        lit("halt", 0, 15, -1, -1, 1);
        issue(6'b100101, 1'b1, 1'b0);
        issue(6'b010010, 1'b1, 1'b0);
        lit("halted_hold", 0, 15, 1, 1, 1);

        issue(6'b100101, 1'b1, 1'b1);
        lit("rst_halt", 0, 0, 0, 0, 0);

        issue(6'b100101, 1'b1, 1'b0);
        issue(6'b001010, 1'b1, 1'b0);
        issue(6'b100011, 1'b1, 1'b0);
        issue(6'b010010, 1'b1, 1'b1);
        lit("rst_mid", 0, 0, 0, 0, 0);
        issue(6'b010010, 1'b1, 1'b0);
        lit("bank_clr", 0, 1, 1, 0, 0);

        issue(6'b000000, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/acc_cpu_param.md
# acc_cpu_param

Parametrised accumulator CPU core, next generation of the team's tiny pin-driven accumulator machine. It executes one externally supplied instruction per valid cycle against an accumulator and a register bank, and it tracks a program counter that the off-chip instruction source follows. Compared with the previous generation, it adds:
- a valid qualifier,
- zero/carry flags,
- more unary ops,
- a halt state,
- separate, fully synchronous outputs.

## Interface
- DATA_W, 8, accumulator/bank word width (>= 5)
- REG_N, 8, bank depth; power of 2, 2..2^(INS_W-3)
- PC_W, 8, program counter width
- INS_W, 6, instruction width (>= 6); immediate field is INS_W-1 bits
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- ins_i  in  INS_W  instruction word
- ins_valid_i  in  1  instruction present this cycle; ignored when low
- pc_o  out  PC_W  program counter (registered)
- acc_o  out  DATA_W  accumulator (registered)
- zero_o  out  1  zero flag
- carry_o  out  1  carry flag
- halted_o  out  1  core in HALT state

## Operation
- Decoding:
  - RA = ins_i[REG_AW-1:0], where REG_AW = log2(REG_N).
  - op = ins_i[INS_W-2:INS_W-3].
  - sub = ins_i[2:0].
- LOAD, ins_i[INS_W-1]=1:
  - acc <= sign-extend(ins_i[INS_W-2:0]) to DATA_W.
  - carry unchanged.
- op=01, STORE: bank[RA] <= acc.
- op=10, ADD: {carry, acc} <= bank[RA] + acc (DATA_W+1 bit sum).
- op=11, BRANCH: if bank[RA] > acc (unsigned), pc <= pc - acc[PC_W-1:0] (mod 2^PC_W) instead of pc+1.
- op=00, MISC, selected by sub:
  - 000 NOP
  - 001 NOT: acc <= ~acc
  - 010 NEG: acc <= -acc
  - 011 SHL: {carry, acc} <= {acc, 0}
  - 100 SHR: arithmetic right shift; carry <= acc[0]
  - 101 HALT
  - 110..111 NOP
  - For MISC ops, bits between sub and op are don't-care.
- zero is updated on every acc-writing op, computed as (new acc == 0). STORE/BRANCH/NOP/HALT leave both flags unchanged.
- PC:
  - Each executed non-halt instruction advances pc by 1, or takes the branch.
  - pc wraps modulo 2^PC_W.
- State machine, two states:
  - RUN: executes instructions while ins_valid_i=1.
  - HALT: entered when a HALT instruction executes (pc still advances by 1 on that instruction). It ignores all instructions and holds all state. It is left only by rst.
- ins_valid_i=0 in RUN: no state changes.

## Timing
- Single-cycle execute: the effect of a valid instruction sampled at edge N is visible on the outputs after edge N.
- STORE followed by ADD/BRANCH on the same RA in the next cycle sees the stored value (no hazard).
- Reset, at the edge with rst=1, regardless of state or mid-sequence:
  - pc_o=0, acc_o=0, zero_o=0, carry_o=0, halted_o=0
  - all bank entries 0; state RUN
- rst has priority over any instruction on the same edge.
- BRANCH with acc=0 and bank[RA]>0 gives pc <= pc (tight self-loop); it is legal.
- Outputs are direct register outputs. No clock-level muxing of pc/acc onto shared pins; a pin wrapper selects them externally.

## Configuration
- ACC_CPU_SAT_EN:
  - Defined: ADD is unsigned-saturating. On carry-out, acc <= all ones and carry_o <= 1.
  - Undefined: ADD wraps modulo 2^DATA_W and carry_o records the carry-out.
  - All other ops are identical in both builds.

## Test plan
All at default parameters.
- Add sequence: rst, then valid 100101 (LOAD 5), 001010 (STORE r2), 100011 (LOAD 3), 010010 (ADD r2) -> acc_o=0x08, pc_o=4, zero_o=0, carry_o=0.
- Branch: continuing with acc=3, bank[2]=5, issue 100011 then 011010 at pc=5 -> pc_o=2. Then LOAD 0x0F (101111) and 011010 -> branch not taken, pc+1.
- Carry/saturation: LOAD -1 (111111 → 0xFF), STORE r0, ADD r0:
  - Without macro: acc_o=0xFE, carry_o=1.
  - With ACC_CPU_SAT_EN: acc_o=0xFF, carry_o=1.
- Unary ops: LOAD 1, then NEG (000010) -> 0xFF. SHR (000100) -> 0xFF with carry 1. NOT (000001) -> 0x00 with zero_o=1.
- Valid/halt: ins_valid_i=0 for 5 cycles -> no output changes. HALT (000101) -> halted_o=1, pc+1. Further LOAD 5 -> ignored. rst -> all outputs 0, RUN.
- Reset mid-run: assert rst on the same edge as a valid ADD -> post-edge outputs all 0 and bank cleared (a subsequent ADD r2 leaves acc=0).
